// File: rtl/apb_pkg.sv
// Shared types for the APB command master: transfer direction, FSM states and
// the timer peripheral register map.
package apb_pkg;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } e_rw;

    typedef enum logic [1:0] {
        APB_IDLE,
        APB_SETUP,
        APB_ACCESS
    } e_apb_state;

    localparam logic [31:0] CTR_STATUS_ADDR = 32'h0000_0000;
    localparam logic [31:0] CTR_GOAL_ADDR   = 32'h0000_0001;
    localparam logic [31:0] CTR_CURR_ADDR   = 32'h0000_0002;

endpackage

// File: rtl/apb_timeout_ctr.sv
// ACCESS-phase wait counter for the APB command master; the whole module is
// compiled only when APB_TIMEOUT_EN is defined, matching its sole instantiation.
`ifdef APB_TIMEOUT_EN
module apb_timeout_ctr #(
    parameter int timeoutCycles = 16,
    localparam int CntWidth = $clog2(timeoutCycles + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    logic [CntWidth-1:0] count;

    // Saturates at the limit so a stalled bus cannot wrap the count back to zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !expired) begin
            count <= count + CntWidth'(1);
        end
    end

    assign expired = (count == CntWidth'(timeoutCycles));

endmodule
`endif

// File: rtl/apb_cmd_master.sv
// APB requester: turns a single-beat valid/ready command into an IDLE/SETUP/ACCESS
// transfer with a one-cycle response pulse. Define APB_TIMEOUT_EN to abort stalled ACCESS phases.
module apb_cmd_master
    import apb_pkg::*;
#(
    parameter int addrWidth     = 32,
    parameter int dataWidth     = 8,
    parameter int timeoutCycles = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [addrWidth-1:0] cmd_addr,
    input  logic [dataWidth-1:0] cmd_wdata,
    output logic                 rsp_valid,
    output logic [dataWidth-1:0] rsp_rdata,
    output logic                 rsp_err,
    output logic                 psel,
    output logic                 penable,
    output logic                 pwrite,
    output logic [addrWidth-1:0] paddr,
    output logic [dataWidth-1:0] pwdata,
    input  logic [dataWidth-1:0] prdata,
    input  logic                 pready,
    input  logic                 pslverr
);

    e_apb_state state;
    logic       timeout_hit;

    assign cmd_ready = (state == APB_IDLE);

`ifdef APB_TIMEOUT_EN
    apb_timeout_ctr #(
        .timeoutCycles(timeoutCycles)
    ) u_timeout_ctr (
        .clk    (clk),
        .reset  (reset),
        .clr    (state == APB_SETUP),
        .inc    ((state == APB_ACCESS) && !pready),
        .expired(timeout_hit)
    );
`else
    // No timeout in this build; the expression is always false but keeps the parameter referenced.
    assign timeout_hit = (timeoutCycles < 0);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= APB_IDLE;
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                APB_IDLE: begin
                    psel    <= 1'b0;
                    penable <= 1'b0;
                    if (cmd_valid) begin
                        paddr  <= cmd_addr;
                        pwrite <= cmd_write;
                        pwdata <= cmd_wdata;
                        psel   <= 1'b1;
                        state  <= APB_SETUP;
                    end
                end
                APB_SETUP: begin
                    penable <= 1'b1;
                    state   <= APB_ACCESS;
                end
                APB_ACCESS: begin
                    // pready takes priority over a timeout expiring in the same cycle.
                    if (pready) begin
                        rsp_valid <= 1'b1;
                        rsp_rdata <= (e_rw'(pwrite) == WRITE) ? '0 : prdata;
                        rsp_err   <= pslverr;
                        psel      <= 1'b0;
                        penable   <= 1'b0;
                        state     <= APB_IDLE;
                    end else if (timeout_hit) begin
                        rsp_valid <= 1'b1;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b1;
                        psel      <= 1'b0;
                        penable   <= 1'b0;
                        state     <= APB_IDLE;
                    end
                end
                default: begin
                    psel    <= 1'b0;
                    penable <= 1'b0;
                    state   <= APB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/apb_cmd_master.md
Name: apb_cmd_master

Overview:
- Upstream APB requester that feeds the timer peripheral's slave port.
- Converts a single-beat command handshake (valid/ready) from a CPU-side or test sequencer into a compliant APB IDLE→SETUP→ACCESS transfer.
- Returns read data and the error flag as a one-cycle response pulse.
- One outstanding transfer at a time; sits between the command source and `timer` (or any APB slave on the same bus).

Parameters:
- addrWidth, 32, width of cmd_addr and paddr.
- dataWidth, 8, width of write and read data buses.
- timeoutCycles, 16, maximum ACCESS cycles waiting for pready (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  addrWidth  target address.
- cmd_wdata  in  dataWidth  write data.
- rsp_valid  out  1  one-cycle pulse: transfer finished.
- rsp_rdata  out  dataWidth  read data (0 on writes).
- rsp_err  out  1  slave error, or timeout when the optional feature is enabled.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- paddr  out  addrWidth  APB address.
- pwdata  out  dataWidth  APB write data.
- prdata  in  dataWidth  APB read data.
- pready  in  1  APB ready / wait-state control.
- pslverr  in  1  APB slave error.

Behaviour:
- Reset (reset = 0, asynchronous):
  - State goes to IDLE.
  - psel, penable, pwrite, rsp_valid, rsp_err = 0; paddr, pwdata, rsp_rdata = 0.
  - cmd_ready = 1.
- FSM has states IDLE, SETUP, ACCESS. All APB outputs are registered.
- cmd_ready = (state == IDLE), combinational from state only.
- IDLE:
  - On cmd_valid && cmd_ready, latch cmd_addr, cmd_write and cmd_wdata into paddr/pwrite/pwdata.
  - Set psel = 1, penable = 0; next state is SETUP.
  - Without a command, all APB outputs hold their previous paddr/pwdata values with psel = penable = 0.
- SETUP: exactly one cycle; set penable = 1; next state is ACCESS.
- ACCESS:
  - paddr, pwrite and pwdata are stable; psel = penable = 1.
  - While pready = 0: stay in ACCESS, outputs unchanged.
  - On the first cycle with pready = 1:
    - Sample prdata (reads only; writes give rsp_rdata = 0) and pslverr.
    - Drive rsp_valid = 1 for exactly the next cycle, and clear psel and penable.
    - Return to IDLE.
- Latency and throughput:
  - Zero-wait transfer: cmd accepted at cycle 0, psel rises at cycle 1, penable at cycle 2, rsp_valid at cycle 3.
  - Each wait state adds 1 cycle.
  - cmd_ready re-asserts in the rsp_valid cycle. Back-to-back commands sustain 1 transfer per 3 cycles, with psel low for at least one cycle between transfers.
- Command inputs are ignored while cmd_ready = 0. The source must hold them until accepted.
- rsp_rdata and rsp_err hold their values until the next response. No response backpressure.
- Reset asserted mid-transfer: psel and penable drop immediately, no rsp_valid is issued, and the command is lost.
- pslverr is sampled only when pready = 1 in ACCESS. It is ignored otherwise.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- Defined:
  - A counter (width $clog2(timeoutCycles+1)) clears on SETUP→ACCESS and increments each ACCESS cycle with pready = 0.
  - When it reaches timeoutCycles, the transfer aborts: psel and penable go to 0, rsp_valid = 1, rsp_err = 1, rsp_rdata = 0, and the FSM returns to IDLE.
  - pready = 1 in the same cycle as the count reaching timeoutCycles completes the transfer normally, i.e. pready wins.
- Not defined: ACCESS waits indefinitely for pready and no counter logic exists.

Decomposition:
- Package apb_pkg contains:
  - typedef enum e_rw {READ = 0, WRITE = 1}.
  - typedef enum e_apb_state {APB_IDLE, APB_SETUP, APB_ACCESS}.
  - Localparams for the timer register map: CTR_STATUS_ADDR, CTR_GOAL_ADDR, CTR_CURR_ADDR.
- One natural sub-module: apb_timeout_ctr, instantiated only under APB_TIMEOUT_EN.

Test Plan:
- After reset, check reset values: psel = penable = 0, cmd_ready = 1, rsp_valid = 0.
- Read at addr 0 with timer idle → psel high at cycle 1, penable at cycle 2, rsp_valid at cycle 3, rsp_rdata = 0, rsp_err = 0.
- Write 25 to addr 1, then write 0x01 to addr 0, then wait 30 cycles and read addr 0 → rsp_rdata[3:2] = 2 (COMPLETE), rsp_rdata[0] = 1.
- Slave model holds pready = 0 for 3 ACCESS cycles on a write of 0xA5 to addr 1 → paddr = 1, pwdata = 0xA5, psel = penable = 1 are stable for 4 cycles; rsp_valid arrives at cycle 6.
- cmd_valid held high with 2 queued commands → second accepted in the rsp_valid cycle of the first; psel low for at least 1 cycle between them; reset pulsed low during SETUP of a third → psel = 0 immediately, no rsp_valid.
- With APB_TIMEOUT_EN and timeoutCycles = 16, pready tied 0 → rsp_valid with rsp_err = 1 after 16 ACCESS cycles, then cmd_ready = 1.
